// File: rtl/rep_sequencer.sv
// rep_sequencer: expands a REP-prefixed instruction into one downstream issue
// per ECX iteration, writing the decremented ECX back with each issue.
// Non-REP instructions pass straight through while the sequencer is idle.
module rep_sequencer #(
  parameter int IADDRW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_rep,
  input  logic [IADDRW-1:0] in_pc,
  input  logic [31:0]       ecx_in,
  input  logic              busy_ahead,
  input  logic              pending_int,
  output logic              hold_int,
  output logic              int_window,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IADDRW-1:0] out_pc,
  output logic              wb_valid,
  output logic [2:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic [2:0]        wb_size,
  output logic              rep_active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  // Constant write-back target: ECX, 32-bit; PC rides along unchanged.
  assign wb_reg     = 3'b001;
  assign wb_size    = 3'd3;
  assign out_pc     = in_pc;
  assign rep_active = (state_q != ST_IDLE);

  // State and iteration-count registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, count update and handshake outputs; flush beats any handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_valid  = 1'b0;
    in_ready   = 1'b0;
    wb_valid   = 1'b0;
    wb_data    = 32'd0;
    hold_int   = 1'b0;
    int_window = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (in_rep) begin
          if (in_valid) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          out_valid = in_valid;
          in_ready  = out_ready;
        end
      end
      ST_WAIT: begin
        hold_int = pending_int;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!busy_ahead) begin
          if (ecx_in == 32'd0) begin
            // Zero count: retire the instruction without issuing anything.
            in_ready = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_d   = ecx_in;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ISSUE: begin
        hold_int = pending_int;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            wb_valid = 1'b1;
            wb_data  = cnt_q - 32'd1;
            cnt_d    = cnt_q - 32'd1;
            if (cnt_q == 32'd1) begin
              // Last iteration completes even with an interrupt pending.
              in_ready = 1'b1;
              state_d  = ST_IDLE;
            end else if (pending_int) begin
              state_d = ST_PAUSE;
            end else begin
              state_d = ST_ISSUE;
            end
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_PAUSE: begin
        // Parked on an iteration boundary until the pipeline is flushed and
        // the instruction refetched with the partially decremented ECX.
        int_window = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rep_sequencer.sv
// Self-checking bench for rep_sequencer: a table of idle pass-through vectors
// followed by hand-written multi-cycle REP sequences.
module tb_rep_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_rep;
  logic [31:0] in_pc;
  logic [31:0] ecx_in;
  logic        busy_ahead;
  logic        pending_int;
  logic        hold_int;
  logic        int_window;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic        wb_valid;
  logic [2:0]  wb_reg;
  logic [31:0] wb_data;
  logic [2:0]  wb_size;
  logic        rep_active;

  int n_checks = 0;
  int n_pass   = 0;

  rep_sequencer #(.IADDRW(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rep(in_rep), .in_pc(in_pc),
    .ecx_in(ecx_in), .busy_ahead(busy_ahead), .pending_int(pending_int),
    .hold_int(hold_int), .int_window(int_window),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_size(wb_size),
    .rep_active(rep_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv;
    logic rep;
    logic ordy;
    logic fl;
    logic e_ov;
    logic e_ir;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic quiet();
    in_valid    = 1'b0;
    in_rep      = 1'b0;
    flush       = 1'b0;
    busy_ahead  = 1'b0;
    pending_int = 1'b0;
    out_ready   = 1'b1;
  endtask

  // Offer a REP instruction from IDLE and step through WAIT into ISSUE.
  task automatic start_rep(input logic [31:0] ecx);
    in_valid = 1'b1; in_rep = 1'b1; ecx_in = ecx; busy_ahead = 1'b0;
    settle();
    chk("rep_offer_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rep_offer_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    settle();
    chk("wait_out_valid", {31'd0, out_valid}, 32'd0);
    chk("wait_active", {31'd0, rep_active}, 32'd1);
    tick();
  endtask

  task automatic issue_chk(input logic [31:0] exp_data, input logic exp_ir);
    settle();
    chk("issue_out_valid", {31'd0, out_valid}, 32'd1);
    chk("issue_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("issue_wb_data", wb_data, exp_data);
    chk("issue_in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
  endtask

  initial begin
    vecs[0] = '{iv:1'b1, rep:1'b0, ordy:1'b1, fl:1'b0, e_ov:1'b1, e_ir:1'b1};
    vecs[1] = '{iv:1'b1, rep:1'b0, ordy:1'b0, fl:1'b0, e_ov:1'b1, e_ir:1'b0};
    vecs[2] = '{iv:1'b0, rep:1'b0, ordy:1'b1, fl:1'b0, e_ov:1'b0, e_ir:1'b1};
    vecs[3] = '{iv:1'b1, rep:1'b0, ordy:1'b1, fl:1'b1, e_ov:1'b0, e_ir:1'b0};
    vecs[4] = '{iv:1'b1, rep:1'b1, ordy:1'b1, fl:1'b1, e_ov:1'b0, e_ir:1'b0};

    // Reset state, with an interrupt pending and a non-REP offer.
    quiet();
    ecx_in = 32'd0;
    in_pc  = 32'h0000_1000;
    reset  = 1'b1;
    in_valid = 1'b1;
    pending_int = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_hold_int", {31'd0, hold_int}, 32'd0);
    chk("rst_int_window", {31'd0, int_window}, 32'd0);
    chk("rst_active", {31'd0, rep_active}, 32'd0);
    chk("wb_reg", {29'd0, wb_reg}, 32'd1);
    chk("wb_size", {29'd0, wb_size}, 32'd3);
    tick();
    tick();
    reset = 1'b0;
    quiet();
    tick();

    // Idle pass-through and flush vectors.
    for (int i = 0; i < 5; i++) begin
      in_valid = vecs[i].iv; in_rep = vecs[i].rep;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      in_pc = 32'hA000_0000 + 32'(i * 4);
      settle();
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
      chk($sformatf("vec%0d_wb_valid", i), {31'd0, wb_valid}, 32'd0);
      chk($sformatf("vec%0d_out_pc", i), out_pc, 32'hA000_0000 + 32'(i * 4));
      tick();
      chk($sformatf("vec%0d_active_after", i), {31'd0, rep_active}, 32'd0);
    end
    quiet();

    // ECX=3: three back-to-back iterations, completion with the third.
    in_pc = 32'h0000_2000;
    start_rep(32'd3);
    issue_chk(32'd2, 1'b0);
    chk("rep3_out_pc", out_pc, 32'h0000_2000);
    tick();
    issue_chk(32'd1, 1'b0);
    tick();
    issue_chk(32'd0, 1'b1);
    in_valid = 1'b0;
    tick();
    settle();
    chk("rep3_idle", {31'd0, rep_active}, 32'd0);
    chk("rep3_idle_wb", {31'd0, wb_valid}, 32'd0);
    quiet();

    // ECX=0: retired from WAIT with no issue.
    in_valid = 1'b1; in_rep = 1'b1; ecx_in = 32'd0;
    tick();
    settle();
    chk("ecx0_in_ready", {31'd0, in_ready}, 32'd1);
    chk("ecx0_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ecx0_wb_valid", {31'd0, wb_valid}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("ecx0_idle", {31'd0, rep_active}, 32'd0);
    quiet();

    // Older work in flight for 4 cycles, hold_int tracks pending_int.
    in_valid = 1'b1; in_rep = 1'b1; ecx_in = 32'd2; busy_ahead = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      pending_int = i[0];
      settle();
      chk("busy_hold_int", {31'd0, hold_int}, {31'd0, i[0]});
      chk("busy_out_valid", {31'd0, out_valid}, 32'd0);
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      chk("busy_active", {31'd0, rep_active}, 32'd1);
      tick();
    end
    busy_ahead = 1'b0; pending_int = 1'b0;
    tick();
    issue_chk(32'd1, 1'b0);
    tick();
    issue_chk(32'd0, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("busy_done_idle", {31'd0, rep_active}, 32'd0);
    quiet();

    // ECX=5, interrupt on 2nd iteration -> PAUSE until flush.
    start_rep(32'd5);
    issue_chk(32'd4, 1'b0);
    tick();
    pending_int = 1'b1;
    issue_chk(32'd3, 1'b0);
    chk("int_hold_in_issue", {31'd0, hold_int}, 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("pause_int_window", {31'd0, int_window}, 32'd1);
      chk("pause_hold_int", {31'd0, hold_int}, 32'd0);
      chk("pause_out_valid", {31'd0, out_valid}, 32'd0);
      chk("pause_in_ready", {31'd0, in_ready}, 32'd0);
      chk("pause_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("pause_wb_data", wb_data, 32'd0);
      tick();
    end
    flush = 1'b1; in_valid = 1'b0;
    settle();
    chk("pause_flush_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("pause_flush_idle", {31'd0, rep_active}, 32'd0);
    chk("pause_flush_window", {31'd0, int_window}, 32'd0);
    quiet();

    // Interrupt on the final iteration does not pause.
    start_rep(32'd1);
    pending_int = 1'b1;
    issue_chk(32'd0, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("last_int_idle", {31'd0, rep_active}, 32'd0);
    chk("last_int_window", {31'd0, int_window}, 32'd0);
    quiet();

    // Flush coincident with an ISSUE handshake.
    start_rep(32'd4);
    flush = 1'b1;
    settle();
    chk("flush_issue_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_issue_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_issue_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("flush_issue_idle", {31'd0, rep_active}, 32'd0);
    quiet();

    // Reset asserted mid-ISSUE abandons the instruction immediately.
    start_rep(32'd4);
    issue_chk(32'd3, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_active", {31'd0, rep_active}, 32'd0);
    chk("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_hold_int", {31'd0, hold_int}, 32'd0);
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    settle();
    chk("rst_mid_after_wb", {31'd0, wb_valid}, 32'd0);
    chk("rst_mid_after_active", {31'd0, rep_active}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
